// File: rtl/mcu_rstgen_const_pkg.sv
// Shared constants for the system reset generator: FSM state encoding and
// reset-cause bit positions.
package mcu_rstgen_const_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ASSERT  = 2'b01,
    ST_RELEASE = 2'b10
  } rst_state_e;

  localparam int unsigned CAUSE_SYS    = 0;
  localparam int unsigned CAUSE_WDOG   = 1;
  localparam int unsigned CAUSE_LOCKUP = 2;
  localparam int unsigned CAUSE_POR    = 3;
  localparam int unsigned CAUSE_W      = 4;

  localparam logic [CAUSE_W-1:0] CAUSE_POR_ONLY = CAUSE_W'(1) << CAUSE_POR;

endpackage

// File: rtl/mcu_rst_sync2.sv
// Two-flop synchronizer for level request inputs; both stages clear on
// asynchronous reset.
module mcu_rst_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mcu_rstgen.sv
// System reset generator: stretches accepted reset requests into a fixed
// HRESETn low pulse, then a release hold-off, and keeps sticky cause flags.
module mcu_rstgen
  import mcu_rstgen_const_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned RELEASE_CYCLES = 4,
  parameter int unsigned CNT_W          = 8
) (
  input  logic               FCLK,
  input  logic               PORESET,
  input  logic               SYSRESETREQ,
  input  logic               WDOGRESETREQ,
  input  logic               LOCKUP,
  input  logic               LOCKUPRESET,
  input  logic               RSTCAUSE_CLR,
  output logic               HRESETn,
  output logic               RSTBUSY,
  output logic [CAUSE_W-1:0] RSTCAUSE
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES - 1);

  logic [3:0]         req_raw;
  logic [3:0]         req_sync;
  logic               lk_req;
  logic               any_req;
  logic [CAUSE_W-1:0] req_bits;

  rst_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [CAUSE_W-1:0] cause_set;
  logic               hresetn_q, hresetn_d;

  assign req_raw = {LOCKUPRESET, LOCKUP, WDOGRESETREQ, SYSRESETREQ};

  mcu_rst_sync2 #(.WIDTH(4)) u_req_sync (
    .clk_i (FCLK),
    .rst_i (PORESET),
    .d_i   (req_raw),
    .q_o   (req_sync)
  );

  assign lk_req  = req_sync[2] & req_sync[3];
  assign any_req = req_sync[0] | req_sync[1] | lk_req;

  always_comb begin
    req_bits               = '0;
    req_bits[CAUSE_SYS]    = req_sync[0];
    req_bits[CAUSE_WDOG]   = req_sync[1];
    req_bits[CAUSE_LOCKUP] = lk_req;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_set = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d   = ST_ASSERT;
          cnt_d     = '0;
          cause_set = req_bits;
        end
      end
      ST_ASSERT: begin
        cause_set = req_bits;
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q == REL_LAST) begin
          cnt_d = '0;
          // A request still held at the end of hold-off restarts directly,
          // so RSTBUSY never drops between back-to-back resets.
          if (any_req) begin
            state_d   = ST_ASSERT;
            cause_set = req_bits;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    cause_d   = (RSTCAUSE_CLR ? '0 : cause_q) | cause_set;
    hresetn_d = (state_d != ST_ASSERT);
  end

  always_ff @(posedge FCLK or posedge PORESET) begin
    if (PORESET) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      cause_q   <= CAUSE_POR_ONLY;
      hresetn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      hresetn_q <= hresetn_d;
    end
  end

  assign HRESETn  = hresetn_q;
  assign RSTBUSY  = (state_q != ST_IDLE);
  assign RSTCAUSE = cause_q;

endmodule

// File: tb/tb_mcu_rstgen.sv
// Bench for mcu_rstgen: directed scenarios plus random request traffic, scored
// against a window-based reference model of reset pulses and cause flags.
module tb_mcu_rstgen;

  localparam int HOLD = 16;
  localparam int REL  = 4;
  localparam int MAXC = 8192;

  logic       FCLK = 1'b0;
  logic       PORESET = 1'b1;
  logic       SYSRESETREQ = 1'b0;
  logic       WDOGRESETREQ = 1'b0;
  logic       LOCKUP = 1'b0;
  logic       LOCKUPRESET = 1'b0;
  logic       RSTCAUSE_CLR = 1'b0;
  logic       HRESETn;
  logic       RSTBUSY;
  logic [3:0] RSTCAUSE;

  mcu_rstgen #(
    .HOLD_CYCLES    (HOLD),
    .RELEASE_CYCLES (REL),
    .CNT_W          (8)
  ) dut (
    .FCLK         (FCLK),
    .PORESET      (PORESET),
    .SYSRESETREQ  (SYSRESETREQ),
    .WDOGRESETREQ (WDOGRESETREQ),
    .LOCKUP       (LOCKUP),
    .LOCKUPRESET  (LOCKUPRESET),
    .RSTCAUSE_CLR (RSTCAUSE_CLR),
    .HRESETn      (HRESETn),
    .RSTBUSY      (RSTBUSY),
    .RSTCAUSE     (RSTCAUSE)
  );

  always #5 FCLK = ~FCLK;

  int cyc = 0;
  always @(posedge FCLK) cyc <= cyc + 1;

  typedef struct packed {
    logic       hr;
    logic       busy;
    logic [3:0] cause;
  } cyc_exp_t;

  typedef struct {
    int         c;
    logic [3:0] cause;
  } pulse_t;

  cyc_exp_t expq[$];
  pulse_t   pulq[$];

  int n_chk  = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_rise = 0;

  // Stimulus history indexed by cycle: cycle c is the interval after edge c.
  bit       pora[MAXC];
  bit [2:0] rqa[MAXC];
  bit       clra[MAXC];

  int         start_e = -1000;
  int         free_at = -1000;
  logic [3:0] mcause  = 4'b1000;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model to that cycle.
  task automatic step(input bit por, input bit sys, input bit wdog,
                      input bit lk, input bit lkr, input bit clr);
    int       c;
    bit [2:0] rq;
    cyc_exp_t e;
    pulse_t   p;
    @(posedge FCLK);
    #1;
    c = cyc;
    PORESET      = por;
    SYSRESETREQ  = sys;
    WDOGRESETREQ = wdog;
    LOCKUP       = lk;
    LOCKUPRESET  = lkr;
    RSTCAUSE_CLR = clr;
    if (c >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", c, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    pora[c] = por;
    rqa[c]  = {lk & lkr, wdog, sys};
    clra[c] = clr;

    if (por) begin
      mcause  = 4'b1000;
      start_e = c + 1;
      free_at = start_e + HOLD + REL;
    end else if (!pora[c-1]) begin
      // A request reaches the decision three edges after it is driven,
      // provided no power-on reset cleared it on the way.
      rq = (c >= 3 && !pora[c-3] && !pora[c-2]) ? rqa[c-3] : 3'b000;
      if (clra[c-1]) mcause = 4'b0000;
      if (c >= free_at) begin
        if (rq != 3'b000) begin
          start_e = c;
          free_at = c + HOLD + REL;
          mcause  = mcause | {1'b0, rq};
        end
      end else if (c > start_e && c <= start_e + HOLD) begin
        mcause = mcause | {1'b0, rq};
      end
    end

    e.hr    = !(por || (c >= start_e && c < start_e + HOLD));
    e.busy  = (c < free_at);
    e.cause = mcause;
    expq.push_back(e);
    if (c == start_e + HOLD) begin
      p.c     = c;
      p.cause = mcause;
      pulq.push_back(p);
      n_push++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: per-cycle output check plus per-pulse length/timing check.
  logic prev_h = 1'b0;
  int   run    = 0;
  always @(negedge FCLK) begin
    cyc_exp_t e;
    pulse_t   p;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("HRESETn", int'(HRESETn), int'(e.hr));
      chk("RSTBUSY", int'(RSTBUSY), int'(e.busy));
      chk("RSTCAUSE", int'(RSTCAUSE), int'(e.cause));
    end
    if (PORESET) run = 0;
    else if (HRESETn == 1'b0) run++;
    if (prev_h == 1'b0 && HRESETn == 1'b1 && !PORESET) begin
      n_rise++;
      if (pulq.size() == 0) begin
        chk("unexpected_rise", 1, 0);
      end else begin
        p = pulq.pop_front();
        chk("rise_cycle", cyc, p.c);
        chk("low_length", run, HOLD);
        chk("cause_at_rise", int'(RSTCAUSE), int'(p.cause));
      end
      run = 0;
    end
    prev_h = HRESETn;
  end

  initial begin
    bit s, w, l, lr, cl, pr;
    int por_left;
    for (int i = 0; i < MAXC; i++) pora[i] = 1'b1;

    repeat (5) step(1, 0, 0, 0, 0, 0);
    idle(30);

    step(0, 1, 0, 0, 0, 0);
    idle(30);
    step(0, 0, 0, 0, 0, 1);
    idle(5);

    repeat (50) step(0, 0, 0, 1, 0, 0);
    repeat (30) step(0, 0, 0, 1, 1, 0);
    idle(30);

    repeat (2) step(0, 0, 1, 0, 0, 0);
    idle(6);
    repeat (2) step(0, 1, 0, 0, 0, 0);
    idle(30);

    repeat (100) step(0, 0, 1, 0, 0, 0);
    idle(30);

    step(0, 0, 1, 0, 0, 0);
    idle(10);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    idle(40);

    s = 0; w = 0; l = 0; lr = 0; por_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(14) == 0) s  = ~s;
      if ($urandom_range(19) == 0) w  = ~w;
      if ($urandom_range(19) == 0) l  = ~l;
      if ($urandom_range(24) == 0) lr = ~lr;
      cl = ($urandom_range(29) == 0);
      if (por_left > 0) por_left--;
      else if ($urandom_range(599) == 0) por_left = $urandom_range(4, 1);
      pr = (por_left > 0);
      step(pr, s, w, l, lr, cl);
    end
    idle(40);

    @(negedge FCLK);
    #1;
    chk("expq_drained", expq.size(), 0);
    chk("pulses_drained", pulq.size(), 0);
    chk("rise_count", n_rise, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
